// File: rtl/csr_read_arbiter.sv
// csr_read_arbiter: core/debug read port onto the cycle and instret counters.
// Define CSR_SNAPSHOT_EN to give each requester tear-free lo->hi shadows.
module csr_read_arbiter #(
  parameter int DBG_MAX_WAIT = 4,
  parameter int CSR_W        = 64,
  parameter int DATA_W       = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [CSR_W-1:0]  cycle_i,
  input  logic [CSR_W-1:0]  instret_i,
  input  logic              core_req_i,
  input  logic [1:0]        core_sel_i,
  output logic              core_gnt_o,
  output logic              core_rvalid_o,
  output logic [DATA_W-1:0] core_rdata_o,
  input  logic              dbg_req_i,
  input  logic [1:0]        dbg_sel_i,
  output logic              dbg_gnt_o,
  output logic              dbg_rvalid_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              busy_o
);

  localparam int WW =
    (DBG_MAX_WAIT < 1) ? 1 : $clog2(DBG_MAX_WAIT + 1);
  localparam logic [WW-1:0] WMAX = WW'(DBG_MAX_WAIT);

  typedef enum logic {
    IDLE = 1'b0,
    DATA = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [WW-1:0] wait_q, wait_d;
  logic          dbg_force;

  logic [1:0]             gnt;
  logic [1:0][1:0]        sel;
  logic [1:0]             rvalid_q, rvalid_d;
  logic [1:0][DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0][DATA_W-1:0] lo_v, hi_v;

  logic [DATA_W-1:0] cyc_lo, cyc_hi;
  logic [DATA_W-1:0] ins_lo, ins_hi;

`ifdef CSR_SNAPSHOT_EN
  // Index order: [requester][counter], counter 0=cycle 1=instret.
  logic [1:0][1:0][DATA_W-1:0] sh_q, sh_d;
  logic [1:0][1:0]             shv_q, shv_d;
`endif

  assign sel    = {dbg_sel_i, core_sel_i};
  assign cyc_lo = cycle_i[DATA_W-1:0];
  assign cyc_hi = cycle_i[2*DATA_W-1:DATA_W];
  assign ins_lo = instret_i[DATA_W-1:0];
  assign ins_hi = instret_i[2*DATA_W-1:DATA_W];

  // Core wins by default; debug wins once it has waited long enough.
  always_comb begin
    dbg_force = (wait_q == WMAX);
    gnt       = '0;
    if (rst_ni) begin
      if (dbg_req_i && (dbg_force || !core_req_i)) begin
        gnt[1] = 1'b1;
      end else if (core_req_i) begin
        gnt[0] = 1'b1;
      end
    end
  end

  // Count consecutive denied debug cycles, saturating at the limit.
  always_comb begin
    wait_d = '0;
    if (dbg_req_i && !gnt[1]) begin
      wait_d = dbg_force ? wait_q : wait_q + 1'b1;
    end
  end

  // Data-phase tracker: DATA while an rvalid pulse is owed.
  always_comb begin
    state_d = IDLE;
    unique case (state_q)
      IDLE: if (|gnt) state_d = DATA;
      DATA: if (|gnt) state_d = DATA;
    endcase
  end

  // Live counter halves each requester would see this cycle.
  always_comb begin
    for (int r = 0; r < 2; r++) begin
      lo_v[r] = sel[r][1] ? ins_lo : cyc_lo;
      hi_v[r] = sel[r][1] ? ins_hi : cyc_hi;
    end
  end

  // Capture the granted read; rdata holds its last value otherwise.
  always_comb begin
    rvalid_d = gnt;
    rdata_d  = rdata_q;
`ifdef CSR_SNAPSHOT_EN
    sh_d     = sh_q;
    shv_d    = shv_q;
`endif
    for (int r = 0; r < 2; r++) begin
      if (gnt[r]) begin
        if (!sel[r][0]) begin
          rdata_d[r] = lo_v[r];
`ifdef CSR_SNAPSHOT_EN
          sh_d[r][sel[r][1]]  = hi_v[r];
          shv_d[r][sel[r][1]] = 1'b1;
`endif
        end else begin
          rdata_d[r] = hi_v[r];
`ifdef CSR_SNAPSHOT_EN
          if (shv_q[r][sel[r][1]]) begin
            rdata_d[r]          = sh_q[r][sel[r][1]];
            shv_d[r][sel[r][1]] = 1'b0;
          end
`endif
        end
      end
    end
  end

  // Arbitration and FSM state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Returned data and valid pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

`ifdef CSR_SNAPSHOT_EN
  // Per-requester hi-half shadows.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_q  <= '0;
      shv_q <= '0;
    end else begin
      sh_q  <= sh_d;
      shv_q <= shv_d;
    end
  end
`endif

  assign core_gnt_o    = gnt[0];
  assign dbg_gnt_o     = gnt[1];
  assign core_rvalid_o = rvalid_q[0];
  assign dbg_rvalid_o  = rvalid_q[1];
  assign core_rdata_o  = rdata_q[0];
  assign dbg_rdata_o   = rdata_q[1];
  assign busy_o        = (state_q == DATA);

endmodule

// File: tb/tb_csr_read_arbiter.sv
// tb_csr_read_arbiter: directed and random checks of csr_read_arbiter
// against a counter-level reference model.
module tb_csr_read_arbiter;

  localparam int MAXW = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [63:0] cycle_i, instret_i;
  logic        core_req_i, dbg_req_i;
  logic [1:0]  core_sel_i, dbg_sel_i;
  logic        core_gnt_o, core_rvalid_o;
  logic        dbg_gnt_o, dbg_rvalid_o;
  logic [31:0] core_rdata_o, dbg_rdata_o;
  logic        busy_o;

  int n_vec = 0;
  int n_err = 0;

  csr_read_arbiter dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .cycle_i       (cycle_i),
    .instret_i     (instret_i),
    .core_req_i    (core_req_i),
    .core_sel_i    (core_sel_i),
    .core_gnt_o    (core_gnt_o),
    .core_rvalid_o (core_rvalid_o),
    .core_rdata_o  (core_rdata_o),
    .dbg_req_i     (dbg_req_i),
    .dbg_sel_i     (dbg_sel_i),
    .dbg_gnt_o     (dbg_gnt_o),
    .dbg_rvalid_o  (dbg_rvalid_o),
    .dbg_rdata_o   (dbg_rdata_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model state
  int unsigned m_wait;
  logic        m_cg, m_dg;
  logic        m_rv [2];
  logic [31:0] m_rd [2];
  logic        m_busy;
  logic [31:0] m_sh [2][2];
  logic        m_shv [2][2];

  function automatic void m_reset();
    m_wait = 0;
    m_busy = 1'b0;
    for (int r = 0; r < 2; r++) begin
      m_rv[r] = 1'b0;
      m_rd[r] = '0;
      for (int c = 0; c < 2; c++) begin
        m_sh[r][c]  = '0;
        m_shv[r][c] = 1'b0;
      end
    end
  endfunction

  function automatic void m_arb();
    m_dg = dbg_req_i && (!core_req_i || m_wait == MAXW);
    m_cg = core_req_i && !m_dg;
  endfunction

  function automatic logic [31:0] m_read(int r, logic [1:0] s);
    logic [63:0] v;
    logic [31:0] d;
    int c;
    c = s[1] ? 1 : 0;
    v = s[1] ? instret_i : cycle_i;
    d = s[0] ? v[63:32] : v[31:0];
`ifdef CSR_SNAPSHOT_EN
    if (!s[0]) begin
      m_sh[r][c]  = v[63:32];
      m_shv[r][c] = 1'b1;
    end else if (m_shv[r][c]) begin
      d = m_sh[r][c];
      m_shv[r][c] = 1'b0;
    end
`endif
    return d;
  endfunction

  function automatic void m_clock();
    m_arb();
    m_rv[0] = m_cg;
    m_rv[1] = m_dg;
    m_busy  = m_cg | m_dg;
    if (m_cg) m_rd[0] = m_read(0, core_sel_i);
    if (m_dg) m_rd[1] = m_read(1, dbg_sel_i);
    if (dbg_req_i && !m_dg)
      m_wait = (m_wait >= MAXW) ? MAXW : m_wait + 1;
    else
      m_wait = 0;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    m_clock();
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    cycle_i = 64'h0; instret_i = 64'h0;
    core_req_i = 1'b1; core_sel_i = 2'd0;
    dbg_req_i = 1'b1; dbg_sel_i = 2'd1;
    m_reset();
    repeat (2) @(negedge clk_i);
    #1;
    n_vec++;
    if ({core_gnt_o, dbg_gnt_o} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_gnt got=%b%b want=00", core_gnt_o, dbg_gnt_o);
    end
    n_vec++;
    if ({core_rvalid_o, dbg_rvalid_o, busy_o} !== 3'b000 ||
        core_rdata_o !== 32'h0 || dbg_rdata_o !== 32'h0) begin
      n_err++;
      $display("FAIL reset_out got=%b%b%b %h %h want=000 0 0",
               core_rvalid_o, dbg_rvalid_o, busy_o,
               core_rdata_o, dbg_rdata_o);
    end
    core_req_i = 1'b0; dbg_req_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    n_vec++;
    if ({core_rvalid_o, dbg_rvalid_o, busy_o} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_idle got=%b%b%b want=000",
               core_rvalid_o, dbg_rvalid_o, busy_o);
    end
  endtask

  task automatic test_basic_read();
    cycle_i = 64'h0000_0005_FFFF_FFFF;
    core_req_i = 1'b1; core_sel_i = 2'd0;
    #1;
    n_vec++;
    if ({core_gnt_o, dbg_gnt_o} !== 2'b10) begin
      n_err++;
      $display("FAIL basic_gnt got=%b%b want=10", core_gnt_o, dbg_gnt_o);
    end
    tick();
    core_req_i = 1'b0;
    n_vec++;
    if (core_rvalid_o !== 1'b1 || core_rdata_o !== 32'hFFFF_FFFF ||
        busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL basic_data got=%b %h busy=%b want=1 ffffffff busy=1",
               core_rvalid_o, core_rdata_o, busy_o);
    end
    tick();
    n_vec++;
    if (core_rvalid_o !== 1'b0 || core_rdata_o !== 32'hFFFF_FFFF ||
        busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL basic_hold got=%b %h busy=%b want=0 ffffffff busy=0",
               core_rvalid_o, core_rdata_o, busy_o);
    end
  endtask

  task automatic test_snapshot();
    logic [31:0] exp1;
`ifdef CSR_SNAPSHOT_EN
    exp1 = 32'h1;
`else
    exp1 = 32'h2;
`endif
    cycle_i = 64'h1_FFFF_FFFF;
    core_req_i = 1'b1; core_sel_i = 2'd0;
    tick();
    core_req_i = 1'b0;
    n_vec++;
    if (core_rdata_o !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL snap_lo got=%h want=ffffffff", core_rdata_o);
    end
    cycle_i = 64'h2_0000_0000;
    tick();
    cycle_i = 64'h2_0000_0003;
    core_req_i = 1'b1; core_sel_i = 2'd1;
    tick();
    n_vec++;
    if (core_rvalid_o !== 1'b1 || core_rdata_o !== exp1) begin
      n_err++;
      $display("FAIL snap_hi1 got=%b %h want=1 %h",
               core_rvalid_o, core_rdata_o, exp1);
    end
    tick();
    core_req_i = 1'b0;
    n_vec++;
    if (core_rvalid_o !== 1'b1 || core_rdata_o !== 32'h2) begin
      n_err++;
      $display("FAIL snap_hi2 got=%b %h want=1 00000002",
               core_rvalid_o, core_rdata_o);
    end
    tick();
  endtask

  task automatic test_starvation();
    logic ec, ed;
    cycle_i = 64'h0000_0009_0000_0007;
    core_req_i = 1'b1; core_sel_i = 2'd1;
    dbg_req_i = 1'b1; dbg_sel_i = 2'd0;
    for (int k = 0; k < 15; k++) begin
      ec = (k % 5) != 4;
      ed = (k % 5) == 4;
      #1;
      n_vec++;
      if ({core_gnt_o, dbg_gnt_o} !== {ec, ed}) begin
        n_err++;
        $display("FAIL starve_gnt k=%0d got=%b%b want=%b%b",
                 k, core_gnt_o, dbg_gnt_o, ec, ed);
      end
      tick();
      n_vec++;
      if ({core_rvalid_o, dbg_rvalid_o} !== {ec, ed}) begin
        n_err++;
        $display("FAIL starve_rv k=%0d got=%b%b want=%b%b",
                 k, core_rvalid_o, dbg_rvalid_o, ec, ed);
      end
    end
    core_req_i = 1'b0; dbg_req_i = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous();
    instret_i = 64'h1111_2222_3333_4444;
    core_req_i = 1'b1; core_sel_i = 2'd2;
    dbg_req_i = 1'b1; dbg_sel_i = 2'd3;
    #1;
    n_vec++;
    if ({core_gnt_o, dbg_gnt_o} !== 2'b10) begin
      n_err++;
      $display("FAIL simul_gnt0 got=%b%b want=10", core_gnt_o, dbg_gnt_o);
    end
    tick();
    core_req_i = 1'b0;
    instret_i = 64'h5555_6666_7777_8888;
    n_vec++;
    if ({core_rvalid_o, dbg_rvalid_o} !== 2'b10 ||
        core_rdata_o !== 32'h3333_4444) begin
      n_err++;
      $display("FAIL simul_core got=%b%b %h want=10 33334444",
               core_rvalid_o, dbg_rvalid_o, core_rdata_o);
    end
    #1;
    n_vec++;
    if ({core_gnt_o, dbg_gnt_o} !== 2'b01) begin
      n_err++;
      $display("FAIL simul_gnt1 got=%b%b want=01", core_gnt_o, dbg_gnt_o);
    end
    tick();
    dbg_req_i = 1'b0;
    instret_i = 64'h0;
    n_vec++;
    if ({core_rvalid_o, dbg_rvalid_o} !== 2'b01 ||
        dbg_rdata_o !== 32'h5555_6666) begin
      n_err++;
      $display("FAIL simul_dbg got=%b%b %h want=01 55556666",
               core_rvalid_o, dbg_rvalid_o, dbg_rdata_o);
    end
    tick();
    n_vec++;
    if ({core_rvalid_o, dbg_rvalid_o, busy_o} !== 3'b000) begin
      n_err++;
      $display("FAIL simul_end got=%b%b%b want=000",
               core_rvalid_o, dbg_rvalid_o, busy_o);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      n_vec++;
      if ({core_rvalid_o, core_rdata_o} !== {m_rv[0], m_rd[0]} ||
          {dbg_rvalid_o, dbg_rdata_o} !== {m_rv[1], m_rd[1]} ||
          busy_o !== m_busy) begin
        n_err++;
        $display("FAIL rand_out i=%0d got=%b %h %b %h %b want=%b %h %b %h %b",
                 i, core_rvalid_o, core_rdata_o, dbg_rvalid_o, dbg_rdata_o,
                 busy_o, m_rv[0], m_rd[0], m_rv[1], m_rd[1], m_busy);
      end
      core_req_i = ($urandom_range(0, 3) != 0);
      dbg_req_i  = ($urandom_range(0, 2) != 0);
      core_sel_i = 2'($urandom_range(0, 3));
      dbg_sel_i  = 2'($urandom_range(0, 3));
      cycle_i    = {$urandom(), $urandom()};
      instret_i  = {$urandom(), $urandom()};
      #1;
      m_arb();
      n_vec++;
      if ({core_gnt_o, dbg_gnt_o} !== {m_cg, m_dg}) begin
        n_err++;
        $display("FAIL rand_gnt i=%0d got=%b%b want=%b%b",
                 i, core_gnt_o, dbg_gnt_o, m_cg, m_dg);
      end
      tick();
    end
    core_req_i = 1'b0; dbg_req_i = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    instret_i = 64'hABCD_0000_1234_5678;
    core_req_i = 1'b1; core_sel_i = 2'd2;
    @(posedge clk_i);
    #2;
    n_vec++;
    if (core_rvalid_o !== 1'b1 || busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL mid_pre got=%b busy=%b want=1 busy=1",
               core_rvalid_o, busy_o);
    end
    rst_ni = 1'b0;
    #1;
    n_vec++;
    if ({core_rvalid_o, dbg_rvalid_o, busy_o} !== 3'b000 ||
        core_rdata_o !== 32'h0 || dbg_rdata_o !== 32'h0) begin
      n_err++;
      $display("FAIL mid_async got=%b%b%b %h %h want=000 0 0",
               core_rvalid_o, dbg_rvalid_o, busy_o,
               core_rdata_o, dbg_rdata_o);
    end
    core_req_i = 1'b0;
    m_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++;
      if ({core_rvalid_o, dbg_rvalid_o, busy_o} !== 3'b000) begin
        n_err++;
        $display("FAIL mid_after k=%0d got=%b%b%b want=000",
                 k, core_rvalid_o, dbg_rvalid_o, busy_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_snapshot();
    test_starvation();
    test_simultaneous();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/csr_read_arbiter.md
CSR_READ_ARBITER -- requirements
Module: csr_read_arbiter

Interface
REQ-001 SHALL have parameter DBG_MAX_WAIT, default 4, consecutive debug-denied cycles before debug is forced to win.
REQ-002 SHALL have parameter CSR_W, default 64, counter width; DATA_W, default 32, read-data width.
REQ-003 SHALL use one clock; reset is asynchronous and active-low: clk_i  input  1  rising-edge clock.
REQ-004 SHALL have rst_ni  input  1  asynchronous active-low reset.
REQ-005 SHALL have cycle_i  input  64  live cycle counter; instret_i  input  64  live retired-instruction counter.
REQ-006 SHALL have core_req_i  input  1  core read request; core_sel_i  input  2  0=cycle lo, 1=cycle hi, 2=instret lo, 3=instret hi.
REQ-007 SHALL have core_gnt_o  output  1  request accepted this cycle; core_rvalid_o  output  1  data valid; core_rdata_o  output  32  read data.
REQ-008 SHALL have dbg_req_i, dbg_sel_i, dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o with the same widths and meanings for the debug requester.
REQ-009 SHALL have busy_o  output  1  a data phase is in progress.

Function
REQ-010 SHALL grant at most one requester per cycle; gnt_o is combinational from req_i and arbitration state.
REQ-011 SHALL give core fixed priority unless the debug wait counter equals DBG_MAX_WAIT, in which case debug wins.
REQ-012 SHALL increment the wait counter each cycle dbg_req_i=1 and dbg_gnt_o=0, saturating at DBG_MAX_WAIT; clear it on debug grant or dbg_req_i=0.
REQ-013 SHALL register the selected 32-bit half of the counter as sampled in the grant cycle and assert the winner's rvalid_o exactly one cycle later for one cycle.
REQ-014 SHALL accept back-to-back grants: a new grant may occur in the same cycle rvalid_o of the previous one is high.
REQ-015 SHALL hold rdata_o stable when rvalid_o=0 (last returned value).
REQ-016 SHALL implement a two-state FSM: IDLE (no data phase pending) and DATA (rvalid_o due); IDLE->DATA on any grant, DATA->DATA on grant, DATA->IDLE otherwise; busy_o=1 in DATA.
REQ-017 SHALL treat a requester's req_i as a level; a denied request stays pending with no side effect until granted or withdrawn.
REQ-018 SHALL ignore sel_i when the corresponding req_i=0.

Reset
REQ-019 SHALL, on rst_ni=0, immediately force FSM to IDLE, both rvalid_o=0, both rdata_o=0, busy_o=0, wait counter=0, all snapshot registers and valid flags=0.
REQ-020 SHALL discard a data phase in flight when reset asserts mid-operation; no rvalid_o pulse after reset release for it.
REQ-021 SHALL still drive gnt_o combinationally during reset as 0.

Configuration
REQ-022 SHALL support macro CSR_SNAPSHOT_EN.
REQ-023 With CSR_SNAPSHOT_EN defined: a granted lo read (sel 0/2) SHALL latch the matching hi half from the same grant cycle into a per-requester, per-counter shadow and set its valid flag.
REQ-024 With CSR_SNAPSHOT_EN defined: a granted hi read with shadow valid SHALL return the shadow and clear the flag; with flag clear it returns the live hi half.
REQ-025 Without CSR_SNAPSHOT_EN: no shadow registers; hi reads always return the live hi half of the grant cycle.
REQ-026 Shadows of one requester SHALL never affect the other requester's data.

Verification
REQ-027 Reset release, core reads sel=0 with cycle_i=0x0000_0005_FFFF_FFFF -> core_gnt_o=1 same cycle, core_rvalid_o=1 next cycle, core_rdata_o=0xFFFF_FFFF.
REQ-028 Snapshot on: core sel=0 at cycle_i=0x1_FFFF_FFFF, then sel=1 after counter reaches 0x2_0000_0003 -> hi returns 0x0000_0001; repeat sel=1 -> 0x0000_0002.
REQ-029 Snapshot off: same stimulus as REQ-028 -> first hi read returns 0x0000_0002.
REQ-030 Core and debug request continuously -> core granted 4 cycles, debug granted on 5th, pattern repeats; wait counter never exceeds 4.
REQ-031 Simultaneous single-cycle requests: core sel=2, debug sel=3 -> core granted first, debug granted next cycle, each rvalid_o exactly one cycle after its grant.
REQ-032 Assert rst_ni=0 during DATA -> rvalid_o, rdata_o, busy_o go 0 asynchronously; no rvalid_o after rst_ni returns to 1.
